// File: rtl/aidan_mcnay_prime_seq.sv
// Trial-division primality tester; requester side of a val/rdy remainder unit.
// Ports: clk/reset, cand stream in, is_prime stream out, divider req/resp.
module aidan_mcnay_prime_seq #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] cand,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic             is_prime,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_req_val,
  input  logic             div_req_rdy,
  input  logic [nbits-1:0] div_result,
  input  logic             div_resp_val,
  output logic             div_resp_rdy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [nbits-1:0]   D_INIT   = nbits'(2);
  localparam logic [nbits-1:0]   D_ONE    = nbits'(1);
  localparam logic [2*nbits-1:0] DSQ_INIT = (2*nbits)'(4);
  localparam logic [2*nbits-1:0] DSQ_ONE  = (2*nbits)'(1);

  logic [1:0]         state_q, state_d;
  logic [nbits-1:0]   n_q, n_d;
  logic [nbits-1:0]   d_q, d_d;
  logic [nbits-1:0]   opb_q, opb_d;
  logic [2*nbits-1:0] dsq_q, dsq_d;
  logic               prime_q, prime_d;

  logic               dsq_gt_n;
  logic [2*nbits-1:0] dsq_inc;

  assign dsq_gt_n = dsq_q > {{nbits{1'b0}}, n_q};

  // (d+1)^2 = d^2 + 2d + 1, so the square follows d without a multiplier
  assign dsq_inc = dsq_q
                 + {{(nbits-1){1'b0}}, d_q, 1'b0}
                 + DSQ_ONE;

  // all handshake outputs are forced low while reset is held
  assign istream_rdy  = !reset && (state_q == IDLE);
  assign div_req_val  = !reset && (state_q == SEND) && !dsq_gt_n;
  assign div_resp_rdy = !reset && (state_q == WAIT);
  assign ostream_val  = !reset && (state_q == DONE);
  assign is_prime     = prime_q;
  assign div_opa      = n_q;
  assign div_opb      = opb_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    opb_d   = opb_q;
    dsq_d   = dsq_q;
    prime_d = prime_q;
    case (state_q)
      IDLE: begin
        if (istream_val) begin
          n_d   = cand;
          d_d   = D_INIT;
          opb_d = D_INIT;
          dsq_d = DSQ_INIT;
          if (cand < D_INIT) begin
            prime_d = 1'b0;
            state_d = DONE;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        // no divisor up to sqrt(n) found: n is prime
        if (dsq_gt_n) begin
          prime_d = 1'b1;
          state_d = DONE;
        end else if (div_req_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (div_resp_val) begin
          if (div_result == '0) begin
            prime_d = 1'b0;
            state_d = DONE;
          end else begin
            d_d     = d_q + D_ONE;
            opb_d   = d_q + D_ONE;
            dsq_d   = dsq_inc;
            state_d = SEND;
          end
        end
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= D_INIT;
      opb_q   <= '0;
      dsq_q   <= DSQ_INIT;
      prime_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      opb_q   <= opb_d;
      dsq_q   <= dsq_d;
      prime_q <= prime_d;
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_prime_seq.sv
// Scoreboard bench for aidan_mcnay_prime_seq with a behavioural divider.
// Drives at negedge, evaluates handshakes 1 time unit later.
module tb_aidan_mcnay_prime_seq;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] cand = '0;
  logic          istream_val = 1'b0;
  logic          istream_rdy;
  logic          is_prime;
  logic          ostream_val;
  logic          ostream_rdy = 1'b0;
  logic [NB-1:0] div_opa;
  logic [NB-1:0] div_opb;
  logic          div_req_val;
  logic          div_req_rdy = 1'b0;
  logic [NB-1:0] div_result = '0;
  logic          div_resp_val = 1'b0;
  logic          div_resp_rdy;

  aidan_mcnay_prime_seq #(.nbits(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .cand        (cand),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .is_prime    (is_prime),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .div_opa     (div_opa),
    .div_opb     (div_opb),
    .div_req_val (div_req_val),
    .div_req_rdy (div_req_rdy),
    .div_result  (div_result),
    .div_resp_val(div_resp_val),
    .div_resp_rdy(div_resp_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int n;
    bit prime;
    int nreq;
  } exp_t;

  exp_t sbq[$];
  int   cur_n = 0;
  int   nreq = 0;
  int   done_cnt = 0;
  bit   stall_en = 1'b0;

  // textbook definition: no divisor strictly between 1 and n
  function automatic bit ref_prime(int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // trial divisors tried in order 2,3,... while k*k <= n,
  // stopping at the first one that divides n
  function automatic int ref_nreq(int n);
    int c;
    c = 0;
    if (n < 2) return 0;
    for (int k = 2; k * k <= n; k++) begin
      c++;
      if (n % k == 0) return c;
    end
    return c;
  endfunction

  // ideal remainder unit with random stalls
  initial begin : divider
    bit busy;
    bit req_st;
    int dly;
    logic [NB-1:0] sa, sb;
    busy = 0; req_st = 0; dly = 0; sa = '0; sb = '0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        div_req_rdy  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        div_resp_val = 1'b0;
      end else begin
        div_req_rdy = 1'b0;
        if (dly > 0) begin
          dly--;
          div_resp_val = 1'b0;
        end else begin
          div_resp_val = 1'b1;
        end
      end
      #1;
      if (reset) begin
        busy = 0; req_st = 0; dly = 0;
      end else begin
        if (req_st) begin
          chk("req_hold_val", int'(div_req_val), 1);
          chk("req_hold_opa", int'(div_opa), int'(sa));
          chk("req_hold_opb", int'(div_opb), int'(sb));
        end
        req_st = 0;
        if (busy) begin
          chk("one_outstanding", int'(div_req_val), 0);
          if (div_resp_val && div_resp_rdy) busy = 0;
        end else if (div_req_val && div_req_rdy) begin
          chk("req_opa", int'(div_opa), cur_n);
          chk("req_opb", int'(div_opb), nreq + 2);
          nreq++;
          busy = 1;
          div_result = (div_opb != '0) ? (div_opa % div_opb) : '0;
          dly = stall_en ? int'($urandom_range(0, 3)) : 0;
        end else if (div_req_val) begin
          req_st = 1; sa = div_opa; sb = div_opb;
        end
      end
    end
  end

  // output monitor: pops the scoreboard on every ostream transfer
  initial begin : omon
    bit st;
    logic sp;
    exp_t e;
    st = 0; sp = 1'b0;
    forever begin
      @(negedge clk);
      ostream_rdy = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      if (reset) begin
        st = 0;
      end else begin
        if (st) begin
          chk("out_hold_val", int'(ostream_val), 1);
          chk("out_hold_prime", int'(is_prime), int'(sp));
        end
        st = 0;
        if (ostream_val && ostream_rdy) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out", int'(ostream_val), 0);
          end else begin
            e = sbq.pop_front();
            chk($sformatf("prime[%0d]", e.n), int'(is_prime), int'(e.prime));
            chk($sformatf("nreq[%0d]", e.n), nreq, e.nreq);
          end
          done_cnt++;
        end else if (ostream_val) begin
          st = 1; sp = is_prime;
        end
      end
    end
  end

  task automatic issue(int n, bit push, bit ep, int en);
    int start;
    int b;
    start = done_cnt;
    if (push) sbq.push_back('{n, ep, en});
    @(negedge clk);
    cand = NB'(n);
    istream_val = 1'b1;
    #1;
    b = 0;
    while (!istream_rdy && b < 100) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (!istream_rdy) chk("accept_timeout", int'(istream_rdy), 1);
    else begin
      cur_n = n;
      nreq = 0;
    end
    @(negedge clk);
    istream_val = 1'b0;
    cand = NB'($urandom);
    if (push) begin
      b = 0;
      while (done_cnt == start && b < 20000) begin
        @(negedge clk);
        b++;
      end
      if (done_cnt == start) chk($sformatf("done_timeout[%0d]", n), done_cnt, start + 1);
    end
  endtask

  int dn[9] = '{0, 1, 2, 3, 4, 97, 91, 65521, 65535};
  bit dp[9] = '{0, 0, 1, 1, 0, 1, 0, 1, 0};
  int dr[9] = '{0, 0, 0, 0, 1, 8, 6, 254, 2};

  initial begin : main
    int b;
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_istream_rdy", int'(istream_rdy), 0);
    chk("rst_ostream_val", int'(ostream_val), 0);
    chk("rst_req_val", int'(div_req_val), 0);
    chk("rst_resp_rdy", int'(div_resp_rdy), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_istream_rdy", int'(istream_rdy), 1);
    chk("post_ostream_val", int'(ostream_val), 0);
    chk("post_req_val", int'(div_req_val), 0);
    chk("post_resp_rdy", int'(div_resp_rdy), 0);
    chk("post_is_prime", int'(is_prime), 0);
    chk("post_opa", int'(div_opa), 0);
    chk("post_opb", int'(div_opb), 0);

    for (int pass = 0; pass < 2; pass++) begin
      stall_en = (pass == 1);
      for (int i = 0; i < 9; i++) issue(dn[i], 1'b1, dp[i], dr[i]);
    end

    // abandon 97 while a remainder is outstanding
    issue(97, 1'b0, 1'b0, 0);
    #1;
    b = 0;
    while (!div_resp_rdy && b < 200) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("reach_wait", int'(div_resp_rdy), 1);
    reset = 1'b1;
    #1;
    chk("midrst_istream_rdy", int'(istream_rdy), 0);
    chk("midrst_ostream_val", int'(ostream_val), 0);
    chk("midrst_resp_rdy", int'(div_resp_rdy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abandon_istream_rdy", int'(istream_rdy), 1);
    chk("abandon_ostream_val", int'(ostream_val), 0);
    chk("abandon_req_val", int'(div_req_val), 0);
    issue(4, 1'b1, 1'b0, 1);

    for (int v = 0; v < 1024; v++) issue(v, 1'b1, ref_prime(v), ref_nreq(v));

    for (int i = 0; i < 20; i++) begin
      n = int'($urandom_range(0, 65535));
      issue(n, 1'b1, ref_prime(n), ref_nreq(n));
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aidan_mcnay_prime_seq.md
AIDAN_MCNAY_PRIME_SEQ -- requirements
Module: aidan_mcnay_prime_seq

Interface
REQ-001 Parameter: nbits, default 16, width of the candidate, the divisor and the divider operands.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cand  input  nbits  candidate number n to test.
REQ-005 Port: istream_val  input  1  cand valid.
REQ-006 Port: istream_rdy  output  1  block ready to accept cand.
REQ-007 Port: is_prime  output  1  result: 1 = n is prime.
REQ-008 Port: ostream_val  output  1  is_prime valid.
REQ-009 Port: ostream_rdy  input  1  consumer accepts is_prime.
REQ-010 Port: div_opa  output  nbits  dividend to divider (always n).
REQ-011 Port: div_opb  output  nbits  trial divisor d to divider.
REQ-012 Port: div_req_val  output  1  divider request valid.
REQ-013 Port: div_req_rdy  input  1  divider accepts request.
REQ-014 Port: div_result  input  nbits  remainder n mod d from divider.
REQ-015 Port: div_resp_val  input  1  remainder valid.
REQ-016 Port: div_resp_rdy  output  1  block accepts remainder.

Function
REQ-017 The block SHALL be the requester side of the iterative val/rdy remainder unit: it issues (opa, opb) requests and consumes remainders; a transfer on any stream occurs only on a cycle with val and rdy both high.
REQ-018 The FSM SHALL have states IDLE, SEND, WAIT, DONE; istream_rdy = IDLE, div_req_val = SEND and not terminating (REQ-021), div_resp_rdy = WAIT, ostream_val = DONE.
REQ-019 IDLE: on istream_val, register n <= cand, d <= 2, dsq <= 4; if cand < 2, set is_prime <= 0 and go to DONE, else go to SEND.
REQ-020 dsq SHALL be a 2*nbits-wide register tracking d*d exactly, updated incrementally as dsq <= dsq + 2d + 1 when d increments; no multiplier.
REQ-021 SEND: if dsq > n, set is_prime <= 1 and go to DONE without asserting div_req_val that cycle; else assert div_req_val with div_opa = n, div_opb = d, and on div_req_rdy go to WAIT.
REQ-022 div_opa and div_opb SHALL come from registers and SHALL remain stable while div_req_val is high and unaccepted.
REQ-023 WAIT: on div_resp_val, if div_result == 0 set is_prime <= 0 and go to DONE; else d <= d + 1, dsq updated per REQ-020, go to SEND.
REQ-024 DONE: is_prime SHALL hold stable; on ostream_rdy go to IDLE; a new cand is accepted no earlier than the cycle after the DONE handshake.
REQ-025 At most one divider request SHALL be outstanding; no new request until the previous remainder is consumed.
REQ-026 Latency: first div_req_val one cycle after cand accept; DONE entered the cycle after the terminating response or dsq > n detection.
REQ-027 Inputs not named by the current state (e.g. istream_val outside IDLE, div_resp_val outside WAIT) SHALL be ignored.

Reset
REQ-028 While reset is high, all valid/rdy outputs SHALL be 0; on the first clock edge with reset high the FSM SHALL go to IDLE.
REQ-029 After reset: istream_rdy = 1, ostream_val = 0, div_req_val = 0, div_resp_rdy = 0, is_prime = 0, div_opa = div_opb = 0, d = 2, dsq = 4.
REQ-030 Reset mid-operation SHALL abandon the test with no ostream transfer; the divider is reset on the same reset net so no stale response reaches the block.

Verification
REQ-031 cand = 0 and cand = 1 -> is_prime = 0, zero divider requests; cand = 2 and 3 -> is_prime = 1, zero requests.
REQ-032 cand = 97 with an ideal divider -> requests d = 2..9 (8 requests), is_prime = 1; cand = 91 -> requests d = 2..7, remainder 0 at d = 7, is_prime = 0.
REQ-033 cand = 65521 (nbits = 16) -> 254 requests, d = 2..255, is_prime = 1; cand = 65535 -> 2 requests (d = 2, 3), is_prime = 0.
REQ-034 Random stalls on div_req_rdy, div_resp_val and ostream_rdy -> div_opa/div_opb and is_prime held stable while stalled; results unchanged vs. no-stall run.
REQ-035 reset asserted while in WAIT for cand = 97 -> next cycle IDLE, istream_rdy = 1, no ostream_val; next cand = 4 -> one request d = 2, is_prime = 0.
REQ-036 Integrated with the iterative remainder unit, sweep cand = 0..1023 -> is_prime matches a reference prime table for every value.
